// File: rtl/axi_slave_rd_rsp_push_fsm.sv
// Purpose : push stage of the AXI slave read-response path; turns TL read completions into AXI R beats.
// Latency : first beat can be pushed the cycle after the header is accepted; one IDLE cycle per header.
// Backpres: buf_full stalls the burst (no push, no payload accept); hdr_ready is held low for the whole burst.
//
// Ports:
//   clk, arst             clock and synchronous active-low reset
//   hdr_valid/hdr_ready   completion header handshake; hdr_id, hdr_len (beats-1), hdr_resp (AXI RESP)
//   dat_valid/dat_ready   payload beat handshake; dat_data
//   buf_full              downstream response buffer cannot take a beat this cycle
//   push                  write strobe into the response buffer, with push_id/_data/_resp/_last
//   busy                  a burst is in progress

module axi_slave_rd_rsp_push_fsm #(
    parameter int DATA_W = 256,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [ID_W-1:0]   hdr_id,
    input  logic [LEN_W-1:0]  hdr_len,
    input  logic [1:0]        hdr_resp,
    input  logic              dat_valid,
    output logic              dat_ready,
    input  logic [DATA_W-1:0] dat_data,
    input  logic              buf_full,
    output logic              push,
    output logic [ID_W-1:0]   push_id,
    output logic [DATA_W-1:0] push_data,
    output logic [1:0]        push_resp,
    output logic              push_last,
    output logic              busy
);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PUSH_DATA = 2'd1,
        PUSH_ERR  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q,   cnt_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [ID_W-1:0]    id_q,    id_d;
    logic [1:0]         resp_q,  resp_d;

    // State and burst context registers.
    always_ff @(posedge clk) begin
        if (!arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            id_q    <= id_d;
            resp_q  <= resp_d;
        end
    end

    // Next state and outputs. Everything is gated by arst so that a
    // reset cycle never pushes or handshakes, even mid-burst.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        id_d      = id_q;
        resp_d    = resp_q;
        hdr_ready = 1'b0;
        dat_ready = 1'b0;
        push      = 1'b0;
        push_id   = '0;
        push_data = '0;
        push_resp = RESP_OKAY;
        push_last = 1'b0;
        busy      = 1'b0;

        if (arst) begin
            busy = (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    hdr_ready = 1'b1;
                    if (hdr_valid) begin
                        id_d    = hdr_id;
                        len_d   = hdr_len;
                        resp_d  = hdr_resp;
                        cnt_d   = hdr_len;
                        state_d = (hdr_resp == RESP_OKAY) ? PUSH_DATA : PUSH_ERR;
                    end
                end

                PUSH_DATA: begin
                    // Payload is only accepted when the buffer can take it,
                    // so the beat handshake and the push are the same event.
                    dat_ready = !buf_full;
                    push      = dat_valid && !buf_full;
                    push_id   = id_q;
                    push_data = dat_data;
                    push_resp = RESP_OKAY;
                    push_last = (cnt_q == '0);
                    if (push) begin
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - LEN_W'(1);
                        end
                    end
                end

                PUSH_ERR: begin
                    // Error bursts are synthesised locally: no payload is
                    // consumed, each beat carries zero data and the latched RESP.
                    push      = !buf_full;
                    push_id   = id_q;
                    push_data = '0;
                    push_resp = resp_q;
                    push_last = (cnt_q == '0);
                    if (push) begin
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - LEN_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Invariants: never write into a full buffer, and the remaining-beat
    // count can only fall from the loaded length.
    always_ff @(posedge clk) begin
        if (arst) begin
            assert (!(push && buf_full));
            if (state_q != IDLE) begin
                assert (cnt_q <= len_q);
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_rd_rsp_push_fsm.sv
module tb_axi_slave_rd_rsp_push_fsm;

    localparam int DATA_W = 256;
    localparam int ID_W   = 8;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              arst;
    logic              hdr_valid;
    logic              hdr_ready;
    logic [ID_W-1:0]   hdr_id;
    logic [LEN_W-1:0]  hdr_len;
    logic [1:0]        hdr_resp;
    logic              dat_valid;
    logic              dat_ready;
    logic [DATA_W-1:0] dat_data;
    logic              buf_full;
    logic              push;
    logic [ID_W-1:0]   push_id;
    logic [DATA_W-1:0] push_data;
    logic [1:0]        push_resp;
    logic              push_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Running totals of observed pushes and last-beats, sampled mid-cycle.
    int push_cnt = 0;
    int last_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (push) push_cnt++;
        if (push && push_last) last_cnt++;
    end

    axi_slave_rd_rsp_push_fsm #(
        .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .arst(arst),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .hdr_id(hdr_id), .hdr_len(hdr_len), .hdr_resp(hdr_resp),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
        .buf_full(buf_full),
        .push(push), .push_id(push_id), .push_data(push_data),
        .push_resp(push_resp), .push_last(push_last),
        .busy(busy)
    );

    // Tasks start and end 1 time unit after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b0; hdr_valid = 1'b0; hdr_id = '0; hdr_len = '0; hdr_resp = '0;
        dat_valid = 1'b1; dat_data = '0; buf_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (hdr_ready !== 1'b0 || dat_ready !== 1'b0 || push !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_gating: hdr_ready=%b dat_ready=%b push=%b busy=%b, all required 0",
                     hdr_ready, dat_ready, push, busy);
        end
        checks++;
        if (push_id !== '0 || push_resp !== 2'b00 || push_last !== 1'b0 || push_data !== '0) begin
            errors++;
            $display("FAIL reset_push_fields: id=%h resp=%b last=%b, all required 0",
                     push_id, push_resp, push_last);
        end
        next_cycle();
        arst = 1'b1;
        @(negedge clk);
        checks++;
        if (hdr_ready !== 1'b1 || busy !== 1'b0 || push !== 1'b0 || dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: hdr_ready=%b busy=%b push=%b dat_ready=%b, required 1 0 0 0",
                     hdr_ready, busy, push, dat_ready);
        end
        next_cycle();
        dat_valid = 1'b0;
        checks++;
        if (push_cnt !== 0) begin
            errors++;
            $display("FAIL idle_ignores_data: push count %0d, required 0", push_cnt);
        end
    endtask

    task automatic test_okay_burst();
        int p0;
        p0 = push_cnt;
        hdr_valid = 1'b1; hdr_id = 8'd5; hdr_len = 8'd3; hdr_resp = 2'b00;
        @(negedge clk);
        checks++;
        if (hdr_ready !== 1'b1 || push !== 1'b0) begin
            errors++;
            $display("FAIL okay_hdr_accept: hdr_ready=%b push=%b, required 1 0", hdr_ready, push);
        end
        next_cycle();
        hdr_valid = 1'b0;
        dat_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat_data = DATA_W'(32'hA + i);
            @(negedge clk);
            checks++;
            if (push !== 1'b1 || push_data !== DATA_W'(32'hA + i) || push_id !== 8'd5 ||
                push_resp !== 2'b00 || push_last !== (i == 3) || busy !== 1'b1 || hdr_ready !== 1'b0) begin
                errors++;
                $display("FAIL okay_beat%0d: push=%b data=%h id=%h resp=%b last=%b busy=%b hdr_ready=%b, required 1 %h 05 00 %b 1 0",
                         i, push, push_data[31:0], push_id, push_resp, push_last, busy, hdr_ready, 32'hA + i, (i == 3));
            end
            next_cycle();
        end
        dat_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hdr_ready !== 1'b1 || push !== 1'b0) begin
            errors++;
            $display("FAIL okay_end: busy=%b hdr_ready=%b push=%b, required 0 1 0", busy, hdr_ready, push);
        end
        next_cycle();
        checks++;
        if (push_cnt - p0 !== 4) begin
            errors++;
            $display("FAIL okay_count: %0d pushes, required 4", push_cnt - p0);
        end
    endtask

    task automatic test_err_burst();
        hdr_valid = 1'b1; hdr_id = 8'd3; hdr_len = 8'd1; hdr_resp = 2'b10;
        dat_valid = 1'b1; dat_data = {DATA_W{1'b1}};
        next_cycle();
        hdr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (push !== 1'b1 || push_data !== '0 || push_resp !== 2'b10 || push_id !== 8'd3 ||
                push_last !== (i == 1) || dat_ready !== 1'b0) begin
                errors++;
                $display("FAIL err_beat%0d: push=%b data_nonzero=%b resp=%b id=%h last=%b dat_ready=%b, required 1 0 10 03 %b 0",
                         i, push, |push_data, push_resp, push_id, push_last, dat_ready, (i == 1));
            end
            next_cycle();
        end
        dat_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || push !== 1'b0 || dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_end: busy=%b push=%b dat_ready=%b, required 0 0 0", busy, push, dat_ready);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        int p0;
        int beat;
        p0 = push_cnt;
        beat = 0;
        hdr_valid = 1'b1; hdr_id = 8'd7; hdr_len = 8'd4; hdr_resp = 2'b00;
        next_cycle();
        hdr_valid = 1'b0;
        dat_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            // cycles 2..4 are the stall; buf_full drops and dat_valid rises together at cycle 5
            buf_full  = (i >= 2 && i <= 4);
            dat_valid = !(i >= 2 && i <= 4);
            dat_data  = DATA_W'(32'h100 + beat);
            @(negedge clk);
            checks++;
            if (buf_full) begin
                if (push !== 1'b0 || dat_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall%0d: push=%b dat_ready=%b busy=%b, required 0 0 1", i, push, dat_ready, busy);
                end
            end else begin
                if (push !== 1'b1 || push_data !== DATA_W'(32'h100 + beat) || push_last !== (beat == 4)) begin
                    errors++;
                    $display("FAIL bp_beat%0d: push=%b data=%h last=%b, required 1 %h %b",
                             beat, push, push_data[31:0], push_last, 32'h100 + beat, (beat == 4));
                end
                beat++;
            end
            next_cycle();
        end
        buf_full = 1'b0;
        dat_valid = 1'b0;
        checks++;
        if (push_cnt - p0 !== 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: %0d pushes busy=%b, required 5 0", push_cnt - p0, busy);
        end
    endtask

    task automatic test_len0();
        hdr_valid = 1'b1; hdr_id = 8'h11; hdr_len = 8'd0; hdr_resp = 2'b00;
        next_cycle();
        hdr_valid = 1'b0;
        dat_valid = 1'b1; dat_data = DATA_W'(32'h55);
        @(negedge clk);
        checks++;
        if (push !== 1'b1 || push_last !== 1'b1 || push_id !== 8'h11) begin
            errors++;
            $display("FAIL len0_beat: push=%b last=%b id=%h, required 1 1 11", push, push_last, push_id);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || push !== 1'b0) begin
            errors++;
            $display("FAIL len0_end: busy=%b push=%b, required 0 0", busy, push);
        end
        next_cycle();
        dat_valid = 1'b0;
    endtask

    task automatic test_len_max();
        int p0;
        int l0;
        int bad;
        p0 = push_cnt;
        l0 = last_cnt;
        bad = 0;
        hdr_valid = 1'b1; hdr_id = 8'h09; hdr_len = 8'd255; hdr_resp = 2'b00;
        next_cycle();
        // second header waits on the bus for the whole burst
        hdr_id = 8'h22; hdr_len = 8'd0; hdr_resp = 2'b00;
        dat_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dat_data = DATA_W'(i);
            @(negedge clk);
            checks++;
            if (push !== 1'b1 || push_last !== (i == 255) || hdr_ready !== 1'b0 || push_id !== 8'h09) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL max_beat%0d: push=%b last=%b hdr_ready=%b id=%h, required 1 %b 0 09",
                             i, push, push_last, hdr_ready, push_id, (i == 255));
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (hdr_ready !== 1'b1 || push !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL max_second_hdr_accept: hdr_ready=%b push=%b busy=%b, required 1 0 0", hdr_ready, push, busy);
        end
        next_cycle();
        hdr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (push !== 1'b1 || push_id !== 8'h22 || push_last !== 1'b1) begin
            errors++;
            $display("FAIL max_second_burst: push=%b id=%h last=%b, required 1 22 1", push, push_id, push_last);
        end
        next_cycle();
        dat_valid = 1'b0;
        checks++;
        if (push_cnt - p0 !== 257 || last_cnt - l0 !== 2) begin
            errors++;
            $display("FAIL max_count: pushes %0d lasts %0d, required 257 2", push_cnt - p0, last_cnt - l0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int p0;
        p0 = push_cnt;
        hdr_valid = 1'b1; hdr_id = 8'h04; hdr_len = 8'd7; hdr_resp = 2'b00;
        next_cycle();
        hdr_valid = 1'b0;
        dat_valid = 1'b1;
        repeat (2) next_cycle();
        arst = 1'b0;
        @(negedge clk);
        checks++;
        if (push !== 1'b0 || busy !== 1'b0 || dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_gating: push=%b busy=%b dat_ready=%b, required 0 0 0", push, busy, dat_ready);
        end
        next_cycle();
        arst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (push !== 1'b0 || busy !== 1'b0 || hdr_ready !== 1'b1) begin
                errors++;
                $display("FAIL midrst_idle%0d: push=%b busy=%b hdr_ready=%b, required 0 0 1", i, push, busy, hdr_ready);
            end
            next_cycle();
        end
        checks++;
        if (push_cnt - p0 !== 2) begin
            errors++;
            $display("FAIL midrst_count: %0d pushes, required 2", push_cnt - p0);
        end
        hdr_valid = 1'b1; hdr_id = 8'h06; hdr_len = 8'd0; hdr_resp = 2'b00;
        next_cycle();
        hdr_valid = 1'b0;
        dat_data = DATA_W'(32'h77);
        @(negedge clk);
        checks++;
        if (push !== 1'b1 || push_id !== 8'h06 || push_last !== 1'b1 || push_data !== DATA_W'(32'h77)) begin
            errors++;
            $display("FAIL midrst_new_burst: push=%b id=%h last=%b data=%h, required 1 06 1 77",
                     push, push_id, push_last, push_data[31:0]);
        end
        next_cycle();
        dat_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_okay_burst();
        test_err_burst();
        test_backpressure();
        test_len0();
        test_len_max();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_slave_rd_rsp_push_fsm.md
Name: axi_slave_rd_rsp_push_fsm

Overview:
Push stage of the AXI slave response path. Takes read-completion headers and payload beats from the TL receive side, splits each completion into AXI R beats, and pushes them into the downstream response buffer. An internal down-counter, loaded from the AXI length, tracks the remaining beats. The block generates error bursts itself when a completion carries a non-OKAY status.

Parameters:
DATA_W, 256, payload width per beat in bits
ID_W, 8, AXI ID width
LEN_W, 8, AXI burst-length field width; beats = len+1

Ports:
clk  in  1  clock
arst  in  1  reset; synchronous, active-low
hdr_valid  in  1  completion header valid
hdr_ready  out  1  header accept
hdr_id  in  ID_W  AXI ID of the completion
hdr_len  in  LEN_W  beats-1
hdr_resp  in  2  AXI RESP code (00 = OKAY)
dat_valid  in  1  payload beat valid
dat_ready  out  1  payload beat accept
dat_data  in  DATA_W  payload beat
buf_full  in  1  response buffer full
push  out  1  write strobe into the response buffer
push_id  out  ID_W  beat ID
push_data  out  DATA_W  beat data
push_resp  out  2  beat RESP
push_last  out  1  final beat of the burst
busy  out  1  a burst is in progress (state != IDLE)

Behaviour:
- Reset: arst low at a rising clk edge puts the block in IDLE. Count, ID, len and resp registers are all cleared to 0.
- Output gating: while arst is low, hdr_ready, dat_ready, push and busy are 0. All other push_* outputs are 0.
- States: IDLE, PUSH_DATA, PUSH_ERR.
- IDLE:
  - hdr_ready=1 and dat_ready=0.
  - When hdr_valid=1, latch hdr_id, hdr_resp and hdr_len, and load cnt<=hdr_len.
  - Next state is PUSH_DATA if hdr_resp==00, otherwise PUSH_ERR.
  - dat_valid is ignored in IDLE.
- PUSH_DATA:
  - hdr_ready=0 and dat_ready=!buf_full.
  - fire = dat_valid & dat_ready.
  - push=fire, combinational, in the same cycle as the beat handshake.
  - push_data=dat_data, push_id=latched ID, push_resp=00.
  - push_last=(cnt==0).
  - On fire: if cnt==0, go to IDLE; else cnt<=cnt-1.
- PUSH_ERR:
  - hdr_ready=0 and dat_ready=0; no payload is consumed.
  - push=!buf_full.
  - push_data all zeros, push_resp=latched resp, push_last=(cnt==0).
  - Count and exit rules are the same as PUSH_DATA, with fire = push.
- Latency: the first beat can be pushed in the cycle after header acceptance. Every header costs exactly one IDLE cycle, so back-to-back bursts have a one-cycle gap.
- Throughput: one beat per cycle while buf_full=0 and data is available.
- Counter: cnt is LEN_W bits and never wraps. cnt==0 with fire always exits to IDLE, so decrementing below 0 is unreachable.
- Beat count: len=0 produces a single beat with push_last=1. len=2^LEN_W-1 produces 2^LEN_W beats.
- buf_full stall: buf_full=1 freezes cnt and holds state. push=0, and dat_ready=0 in PUSH_DATA.
- Simultaneous events:
  - buf_full deasserting and dat_valid rising in the same cycle produce a push in that cycle.
  - hdr_valid during a burst is held off by hdr_ready=0.
- Reset mid-burst: returns to IDLE on the next edge. The partial burst is discarded and no further pushes occur.
- Invariant: push is never 1 while buf_full=1.

Test Plan:
1. Reset then idle: arst=0 for 2 cycles, then 1 -> hdr_ready=1, busy=0, push=0. dat_valid=1 in IDLE produces no push.
2. OKAY burst, id=5, len=3, data 0xA..0xD streamed with buf_full=0:
   - 4 pushes on consecutive cycles starting the cycle after the header.
   - push_id=5, resp=00.
   - push_last only on the 0xD beat.
   - busy drops the next cycle; hdr_ready=1 again.
3. SLVERR burst, resp=10, len=1:
   - 2 pushes with push_data=0 and push_resp=10; last on the second.
   - dat_ready stays 0 throughout.
4. Backpressure, len=4: assert buf_full for 3 cycles after beat 2 -> push=0 and dat_ready=0 during the stall. Beats 3-5 resume afterwards; exactly 5 pushes total.
5. Boundaries:
   - len=0 gives 1 push with push_last=1.
   - len=255 gives 256 pushes with push_last only on the 256th.
   - A second header presented during the burst is accepted only after return to IDLE.
6. Reset mid-burst: arst=0 after beat 2 of len=7 -> IDLE next edge, no further pushes. A new header with len=0 is then processed normally.
